// File: rtl/cursor_controller.sv
// 3x3 board cursor sequencer: debounces five raw buttons, moves the cursor with row/column wrap,
// and issues one-cycle placement strobes. Optional blink selected by `define CURSOR_BLINK_EN.
module cursor_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int BLINK_CYCLES    = 12500000,
  parameter int START_POS       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_select,
  input  logic [8:0] occupied,
  output logic [3:0] sel_position,
  output logic       place_valid,
  output logic [3:0] place_pos,
  output logic       cursor_on,
  output logic [1:0] fsm_state
);

  typedef enum logic [1:0] {
    ST_READY  = 2'd0,
    ST_PLACE  = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || BLINK_CYCLES < 1 || START_POS < 0 || START_POS > 8) begin : g_bad_param
    $error("cursor_controller: illegal parameter value");
  end

  state_t state;

  // Button bit order: 0 up, 1 down, 2 left, 3 right, 4 select (also the priority order).
  logic [4:0] btn_raw;
  logic [4:0] sync_a;
  logic [4:0] sync_b;
  logic [4:0] deb;
  logic [4:0] deb_q;
  logic [4:0] press;
  logic [DB_W-1:0] db_cnt [5];

  assign btn_raw   = {btn_select, btn_right, btn_left, btn_down, btn_up};
  assign press     = deb & ~deb_q;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_a <= '0;
      sync_b <= '0;
      deb    <= '0;
      deb_q  <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync_a <= btn_raw;
      sync_b <= sync_a;
      deb_q  <= deb;
      for (int i = 0; i < 5; i++) begin
        if (sync_b[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db_cnt[i] <= '0;
          deb[i]    <= sync_b[i];
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Highest-priority move wins; lower pulses in the same cycle are simply dropped.
  logic [3:0] pos_col;
  logic [3:0] move_pos;
  logic       move_hit;
  logic       select_hit;

  assign pos_col    = sel_position % 4'd3;
  assign select_hit = press[4] & ~(|press[3:0]);

  always_comb begin
    move_hit = 1'b1;
    move_pos = sel_position;
    if (press[0]) begin
      move_pos = (sel_position >= 4'd3) ? sel_position - 4'd3 : sel_position + 4'd6;
    end else if (press[1]) begin
      move_pos = (sel_position <= 4'd5) ? sel_position + 4'd3 : sel_position - 4'd6;
    end else if (press[2]) begin
      move_pos = (pos_col == 4'd0) ? sel_position + 4'd2 : sel_position - 4'd1;
    end else if (press[3]) begin
      move_pos = (pos_col == 4'd2) ? sel_position - 4'd2 : sel_position + 4'd1;
    end else begin
      move_hit = 1'b0;
    end
  end

`ifdef CURSOR_BLINK_EN
  localparam int BL_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_CYCLES - 1);
  logic [BL_W-1:0] blink_cnt;
`endif

  // Handshake: place_valid is a pulse with no back-pressure; place_pos is meaningful
  // only while place_valid=1 and otherwise holds the last placed cell.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_READY;
      sel_position <= 4'(START_POS);
      place_valid  <= 1'b0;
      place_pos    <= 4'd0;
      cursor_on    <= 1'b1;
`ifdef CURSOR_BLINK_EN
      blink_cnt    <= '0;
`endif
    end else begin
      place_valid <= 1'b0;
      case (state)
        ST_READY: begin
          if (!enable) begin
            state <= ST_FROZEN;
          end else if (move_hit) begin
            sel_position <= move_pos;
          end else if (select_hit && !occupied[sel_position]) begin
            state       <= ST_PLACE;
            place_valid <= 1'b1;
            place_pos   <= sel_position;
          end
        end
        ST_PLACE:  state <= enable ? ST_READY : ST_FROZEN;
        ST_FROZEN: if (enable) state <= ST_READY;
        default:   state <= ST_READY;
      endcase

      // The next state is FROZEN exactly when enable is low, so visibility keys off enable.
`ifdef CURSOR_BLINK_EN
      if (!enable) begin
        cursor_on <= 1'b0;
        blink_cnt <= '0;
      end else if (state == ST_FROZEN || (state == ST_READY && move_hit)) begin
        cursor_on <= 1'b1;
        blink_cnt <= '0;
      end else if (blink_cnt == BL_LAST) begin
        cursor_on <= ~cursor_on;
        blink_cnt <= '0;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
`else
      cursor_on <= enable;
`endif
    end
  end

endmodule

// File: tb/tb_cursor_controller.sv
// Directed bench for cursor_controller with DEBOUNCE_CYCLES=4 and BLINK_CYCLES=8.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_cursor_controller;

  localparam int DEB = 4;
  localparam int BLK = 8;
`ifdef CURSOR_BLINK_EN
  localparam bit BLINK_ON = 1'b1;
`else
  localparam bit BLINK_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       btn_up, btn_down, btn_left, btn_right, btn_select;
  logic [8:0] occupied;
  logic [3:0] sel_position;
  logic       place_valid;
  logic [3:0] place_pos;
  logic       cursor_on;
  logic [1:0] fsm_state;

  int         n_pass  = 0;
  int         n_total = 0;
  int         pv_count;
  logic [3:0] pv_pos;
  logic [3:0] exp_q[$];
  logic [4:0] mask_q[$];

  // Button masks: bit 0 up, 1 down, 2 left, 3 right, 4 select.
  localparam logic [4:0] M_UP = 5'b00001, M_DN = 5'b00010, M_LT = 5'b00100,
                         M_RT = 5'b01000, M_SEL = 5'b10000;

  always #5 clk = ~clk;

  cursor_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .BLINK_CYCLES   (BLK),
    .START_POS      (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_select  (btn_select),
    .occupied    (occupied),
    .sel_position(sel_position),
    .place_valid (place_valid),
    .place_pos   (place_pos),
    .cursor_on   (cursor_on),
    .fsm_state   (fsm_state)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic set_btn(input logic [4:0] m);
    {btn_select, btn_right, btn_left, btn_down, btn_up} = m;
  endtask

  // Hold the mask for 10 cycles, release, let it settle; count place_valid cycles seen.
  task automatic press(input logic [4:0] m);
    pv_count = 0;
    set_btn(m);
    for (int i = 0; i < 18; i++) begin
      if (i == 10) set_btn(5'b0);
      @(negedge clk);
      if (place_valid === 1'b1) begin
        pv_count++;
        pv_pos = place_pos;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b1;
    occupied = 9'b0;
    pv_pos = 4'd0;
    set_btn(5'b0);
    step(2);
    rst = 1'b0;

    // Reset state
    check("rst_sel", sel_position, 4);
    check("rst_pv", place_valid, 0);
    check("rst_ppos", place_pos, 0);
    check("rst_cursor", cursor_on, 1);
    check("rst_state", fsm_state, 0);

    // First move and its latency: 7 cycles from input rise
    set_btn(M_RT);
    step(6);
    check("lat_before", sel_position, 4);
    step(1);
    check("lat_after", sel_position, 5);
    step(3);
    set_btn(5'b0);
    step(8);
    check("lat_hold", sel_position, 5);

    // Wrap sequence 5 ->3 ->6 ->0 ->2 ->8
    mask_q = '{M_RT, M_DN, M_DN, M_LT, M_UP};
    exp_q  = '{4'd3, 4'd6, 4'd0, 4'd2, 4'd8};
    while (mask_q.size() > 0) begin
      press(mask_q.pop_front());
      check("wrap", sel_position, exp_q.pop_front());
    end

    // Bouncing input never settles long enough
    for (int i = 0; i < 10; i++) begin
      btn_up = (i % 2 == 0);
      step(2);
    end
    btn_up = 1'b0;
    step(10);
    check("bounce", sel_position, 8);

    // Navigate 8 ->2 ->1 ->0 and place
    press(M_DN); check("nav_8dn", sel_position, 2);
    press(M_LT); check("nav_2lt", sel_position, 1);
    press(M_LT); check("nav_1lt", sel_position, 0);
    press(M_SEL);
    check("place0_cnt", pv_count, 1);
    check("place0_pos", pv_pos, 0);
    check("place0_state", fsm_state, 0);
    occupied = 9'b000000001;
    press(M_SEL);
    check("occ_cnt", pv_count, 0);

    // Priority: up beats select at cell 4
    press(M_DN); check("nav_0dn", sel_position, 3);
    press(M_RT); check("nav_3rt", sel_position, 4);
    press(M_UP | M_SEL);
    check("prio_sel", sel_position, 1);
    check("prio_cnt", pv_count, 0);

    // Frozen discards presses
    enable = 1'b0;
    step(1);
    check("frz_state", fsm_state, 2);
    check("frz_cursor", cursor_on, 0);
    press(M_RT);
    check("frz_sel", sel_position, 1);
    check("frz_cnt", pv_count, 0);
    enable = 1'b1;
    step(1);
    check("unfrz_state", fsm_state, 0);
    check("unfrz_cursor", cursor_on, 1);

    // Button held across unfreeze does not fire
    enable = 1'b0;
    step(1);
    set_btn(M_RT);
    step(10);
    enable = 1'b1;
    step(5);
    set_btn(5'b0);
    step(8);
    check("held_sel", sel_position, 1);

    // Place at cell 1, then move to 2
    press(M_SEL);
    check("place1_cnt", pv_count, 1);
    check("place1_pos", pv_pos, 1);
    occupied = 9'b000000011;
    press(M_RT); check("nav_1rt", sel_position, 2);

    // Enable drops during PLACE: strobe still completes, then FROZEN
    set_btn(M_SEL);
    step(6);
    check("pdrop_pre", place_valid, 0);
    step(1);
    check("pdrop_pv", place_valid, 1);
    check("pdrop_pos", place_pos, 2);
    check("pdrop_st", fsm_state, 1);
    enable = 1'b0;
    step(1);
    check("pdrop_pv2", place_valid, 0);
    check("pdrop_frz", fsm_state, 2);
    set_btn(5'b0);
    step(8);
    enable = 1'b1;
    step(1);
    check("pdrop_ready", fsm_state, 0);
    occupied = 9'b000000111;

    // Reset in the middle of PLACE at cell 5
    press(M_DN); check("nav_2dn", sel_position, 5);
    set_btn(M_SEL);
    step(7);
    check("prst_pv", place_valid, 1);
    check("prst_pos", place_pos, 5);
    rst = 1'b1;
    step(1);
    check("prst_pv2", place_valid, 0);
    check("prst_sel", sel_position, 4);
    check("prst_ppos", place_pos, 0);
    set_btn(5'b0);
    step(1);
    rst = 1'b0;

    // Cursor visibility: blink period 8 and move restart (constant 1 without blink)
    step(4);
    set_btn(M_RT);
    step(3);
    check("blink_e7", cursor_on, 1);
    step(1);
    check("blink_e8", cursor_on, BLINK_ON ? 0 : 1);
    step(2);
    check("blink_e10", cursor_on, BLINK_ON ? 0 : 1);
    check("blink_sel_pre", sel_position, 4);
    step(1);
    check("blink_e11", cursor_on, 1);
    check("blink_sel", sel_position, 5);
    step(3);
    set_btn(5'b0);
    step(4);
    check("blink_e18", cursor_on, 1);
    step(1);
    check("blink_e19", cursor_on, BLINK_ON ? 0 : 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
